// File: rtl/fp_accumulator.sv
// fp_accumulator: streaming FP32 vector sum with element count over valid/ready handshakes.
// Optional FP_ACC_STATUS_EN adds sticky per-vector out_nan/out_inf flags.

module parameterized_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, sub, sticky, found, up;
    logic [31:0]       big, sml;
    logic [7:0]        d;
    logic [26:0]       mbig, msml0, msml, norm;
    logic [27:0]       sum28;
    logic [4:0]        lz;
    logic [24:0]       mr;
    logic signed [9:0] e_n, e_r;
    logic [31:0]       calc;
    always_comb begin
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        a_zero = a[30:23] == 8'd0;
        b_zero = b[30:23] == 8'd0;
        swap   = b[30:0] > a[30:0];
        big    = swap ? b : a;
        sml    = swap ? a : b;
        d      = big[30:23] - sml[30:23];
        mbig   = {1'b1, big[22:0], 3'b000};
        msml0  = {1'b1, sml[22:0], 3'b000};
        sticky = |(msml0 & ((27'd1 << d) - 27'd1));
        msml   = (d >= 8'd27) ? 27'd1 : ((msml0 >> d) | {26'd0, sticky});
        sub    = big[31] ^ sml[31];
        sum28  = sub ? ({1'b0, mbig} - {1'b0, msml}) : ({1'b0, mbig} + {1'b0, msml});
        lz     = 5'd0;
        found  = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (sum28[i] && !found) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end
        // Carry-out shifts right keeping a sticky bit; cancellation shifts left.
        norm = sum28[27] ? {sum28[27:2], sum28[1] | sum28[0]} : (sum28[26:0] << lz);
        e_n  = sum28[27] ? $signed({2'b00, big[30:23]}) + 10'sd1
                         : $signed({2'b00, big[30:23]}) - $signed({5'd0, lz});
        up   = norm[2] && ((|norm[1:0]) || norm[3]);
        mr   = {1'b0, norm[26:3]} + {24'd0, up};
        e_r  = e_n + $signed({9'd0, mr[24] & ~mr[23]});
        calc = (sum28 == 28'd0) ? 32'h0000_0000 :
               (e_r >= 10'sd255) ? {big[31], 8'hFF, 23'd0} :
               (e_r <= 10'sd0) ? {big[31], 31'd0} :
               {big[31], e_r[7:0], mr[22:0]};
        result = (a_nan || b_nan) ? 32'h7FC0_0000 :
                 (a_inf && b_inf && (a[31] != b[31])) ? 32'h7FC0_0000 :
                 a_inf ? a :
                 b_inf ? b :
                 (a_zero && b_zero) ? {a[31] & b[31], 31'd0} :
                 a_zero ? b :
                 b_zero ? a : calc;
    end
endmodule

module fp_accumulator #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef FP_ACC_STATUS_EN
    output logic             out_nan,
    output logic             out_inf,
`endif
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic {ACC, OUT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d, out_data_q, out_data_d, sum;
    logic [CNT_W-1:0]   cnt_q, cnt_d, out_count_q, out_count_d, cnt_inc;
    logic               accept;

    parameterized_adder #(.WIDTH(WIDTH)) u_add (.a(acc_q), .b(in_data), .result(sum));

`ifdef FP_ACC_STATUS_EN
    logic nan_q, nan_d, inf_q, inf_d, out_nan_q, out_nan_d, out_inf_q, out_inf_d, beat_nan, beat_inf;
    always_comb begin
        beat_nan  = nan_q || ((&in_data[30:23]) && (|in_data[22:0])) || ((&sum[30:23]) && (|sum[22:0]));
        beat_inf  = inf_q || ((&in_data[30:23]) && !(|in_data[22:0])) || ((&sum[30:23]) && !(|sum[22:0]));
        nan_d     = nan_q;
        inf_d     = inf_q;
        out_nan_d = out_nan_q;
        out_inf_d = out_inf_q;
        if (state_q == ACC && clear) begin
            nan_d = 1'b0;
            inf_d = 1'b0;
        end else if (accept) begin
            nan_d     = in_last ? 1'b0 : beat_nan;
            inf_d     = in_last ? 1'b0 : beat_inf;
            out_nan_d = in_last ? beat_nan : out_nan_q;
            out_inf_d = in_last ? beat_inf : out_inf_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            out_nan_q <= 1'b0;
            out_inf_q <= 1'b0;
        end else begin
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            out_nan_q <= out_nan_d;
            out_inf_q <= out_inf_d;
        end
    end
    assign out_nan = out_nan_q;
    assign out_inf = out_inf_q;
`endif

    always_comb begin
        in_ready    = (state_q == ACC) && !clear;
        accept      = in_valid && in_ready;
        cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (state_q == ACC) begin
            if (clear) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (accept) begin
                acc_d       = in_last ? '0 : sum;
                cnt_d       = in_last ? '0 : cnt_inc;
                out_data_d  = in_last ? sum : out_data_q;
                out_count_d = in_last ? cnt_inc : out_count_q;
                state_d     = in_last ? OUT : ACC;
            end
        end else if (out_ready) begin
            state_d = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = state_q == OUT;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: directed vectors with a queue scoreboard and an independent output monitor.
// Build with FP_ACC_STATUS_EN defined to also check out_nan/out_inf.

module tb_fp_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [15:0] out_count;
`ifdef FP_ACC_STATUS_EN
    logic        out_nan, out_inf;
`endif

    typedef struct {
        logic [31:0] d;
        logic [15:0] c;
        logic        n;
        logic        i;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fp_accumulator #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef FP_ACC_STATUS_EN
        .out_nan(out_nan), .out_inf(out_inf),
`endif
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [15:0] c, input logic n, input logic i);
        exp_t e;
        e.d = d; e.c = c; e.n = n; e.i = i;
        sb.push_back(e);
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) chk("beat_accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", out_data, 32'hxxxxxxxx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_count", 32'(out_count), 32'(e.c));
`ifdef FP_ACC_STATUS_EN
                chk("out_nan", 32'(out_nan), 32'(e.n));
                chk("out_inf", 32'(out_inf), 32'(e.i));
`endif
            end
        end
    end

    initial begin
        int t;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        @(posedge clk); #1;

        push(32'h40C00000, 16'd3, 1'b0, 1'b0);
        beat(32'h3F800000, 1'b0);
        beat(32'h40000000, 1'b0);
        beat(32'h40400000, 1'b1);
        chk("latency_out_valid", 32'(out_valid), 32'd1);

        push(32'h40400000, 16'd1, 1'b0, 1'b0);
        beat(32'h40400000, 1'b1);

        push(32'h00000000, 16'd2, 1'b0, 1'b0);
        beat(32'h3F800000, 1'b0);
        beat(32'hBF800000, 1'b1);

        push(32'h7FC00000, 16'd3, 1'b1, 1'b0);
        beat(32'h3F800000, 1'b0);
        beat(32'h7FC00001, 1'b0);
        beat(32'h40000000, 1'b1);

        push(32'h7F800000, 16'd2, 1'b0, 1'b1);
        beat(32'h7F7FFFFF, 1'b0);
        beat(32'h7F7FFFFF, 1'b1);

        push(32'h7FC00000, 16'd2, 1'b1, 1'b1);
        beat(32'h7F800000, 1'b0);
        beat(32'hFF800000, 1'b1);

        push(32'h3F800000, 16'd2, 1'b0, 1'b0);
        beat(32'h00000001, 1'b0);
        beat(32'h3F800000, 1'b1);

        @(posedge clk); #1;
        out_ready = 1'b0;
        push(32'h40000000, 16'd1, 1'b0, 1'b0);
        beat(32'h40000000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data", out_data, 32'h40000000);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_handshake_in_ready", 32'(in_ready), 32'd1);
        push(32'h3F800000, 16'd1, 1'b0, 1'b0);
        beat(32'h3F800000, 1'b1);

        push(32'h40400000, 16'd1, 1'b0, 1'b0);
        beat(32'h3F800000, 1'b0);
        beat(32'h40000000, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h41000000;
        clear    = 1'b1;
        @(negedge clk);
        chk("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        beat(32'h40400000, 1'b1);

        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(32'h3F800000, 1'b0);
        beat(32'h40000000, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_out_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        push(32'h3F800000, 16'd1, 1'b0, 1'b0);
        beat(32'h3F800000, 1'b1);

        t = 0;
        while (sb.size() != 0 && t < 50) begin
            t++;
            @(posedge clk);
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
